// File: rtl/instr_fetch.sv
// Instruction fetch stage: keeps the PC, issues one byte read at a time over req/ack,
// buffers bytes in a prefetch FIFO and redirects on jumps, discarding stale reads.
//
// state | meaning
// IDLE  | no read outstanding; waits for FIFO space and !halt
// REQ   | read outstanding at mem_addr; its byte is pushed on ack
// DROP  | read outstanding for a pre-jump address; its byte is discarded on ack
module instr_fetch #(
    parameter int              PC_W     = 5,
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [7:0]      mem_rdata,
    input  logic            jmp_en,
    input  logic [PC_W-1:0] jmp_addr,
    input  logic            halt,
    output logic [7:0]      instr,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            mem_req_q, mem_req_d;
    logic [PC_W-1:0] mem_addr_q, mem_addr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [7:0]      fifo_data_q [DEPTH];
    logic [7:0]      fifo_data_d [DEPTH];
    logic [PC_W-1:0] fifo_pc_q [DEPTH];
    logic [PC_W-1:0] fifo_pc_d [DEPTH];

    logic            ack_fire;
    logic            pop;
    logic            push;
    logic [CW-1:0]   count_after;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] drop_target;

    always_comb begin
        ack_fire    = mem_req_q && mem_ack;
        pop         = (count_q != '0) && instr_ready && !jmp_en;
        push        = ack_fire && (state_q == REQ) && !jmp_en && ((count_q != DEPTH_C) || pop);
        count_after = count_q + CW'(push) - CW'(pop);
        pc_inc      = pc_q + PC_W'(1);
        drop_target = jmp_en ? jmp_addr : pc_q;

        state_d     = state_q;
        pc_d        = pc_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        count_d     = count_after;
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        wr_ptr_d    = wr_ptr_q + AW'(push);
        fifo_data_d = fifo_data_q;
        fifo_pc_d   = fifo_pc_q;

        if (push) begin
            fifo_data_d[wr_ptr_q] = mem_rdata;
            fifo_pc_d[wr_ptr_q]   = mem_addr_q;
        end

        // A jump overrides any same-edge push or pop and empties the FIFO.
        if (jmp_en) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            pc_d     = jmp_addr;
        end

        case (state_q)
            IDLE: begin
                if (!halt && (jmp_en || (count_q < DEPTH_C))) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = jmp_en ? jmp_addr : pc_q;
                end
            end
            REQ: begin
                if (jmp_en) begin
                    if (!ack_fire) begin
                        state_d = DROP;
                    end else if (!halt) begin
                        mem_addr_d = jmp_addr;
                    end else begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end else if (ack_fire) begin
                    pc_d = pc_inc;
                    if (!halt && (count_after < DEPTH_C)) begin
                        mem_addr_d = pc_inc;
                    end else begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end
            end
            DROP: begin
                if (ack_fire) begin
                    if (!halt) begin
                        state_d    = REQ;
                        mem_addr_d = drop_target;
                    end else begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= RESET_PC;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fifo_data_q <= '{default: '0};
            fifo_pc_q   <= '{default: '0};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fifo_data_q <= fifo_data_d;
            fifo_pc_q   <= fifo_pc_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = fifo_data_q[rd_ptr_q];
    assign instr_pc    = fifo_pc_q[rd_ptr_q];
    assign instr_valid = (count_q != '0);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: random memory latency, ready, halt and jumps driven against a
// stream-level reference model; a monitor scores the delivered instruction stream.
module tb_instr_fetch;

    localparam int PC_W  = 5;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mem_req;
    logic [PC_W-1:0] mem_addr;
    logic            mem_ack;
    logic [7:0]      mem_rdata;
    logic            jmp_en;
    logic [PC_W-1:0] jmp_addr;
    logic            halt;
    logic [7:0]      instr;
    logic [PC_W-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;

    always #5 clk = ~clk;

    instr_fetch #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .jmp_en(jmp_en), .jmp_addr(jmp_addr), .halt(halt),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
    );

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [7:0]      data;
    } exp_t;

    int errors = 0;
    int checks = 0;

    logic [7:0]      mem [32];
    exp_t            exp_q [$];
    logic [PC_W-1:0] exp_pc;
    bit              stale;

    // knobs set by the main sequence, read by the stimulus process
    int              min_wait = 0;
    int              max_wait = 0;
    int              ready_mode = 0;
    int              halt_mode = 0;
    int              jmp_pct = 0;
    int              force_mode = 0;
    logic [PC_W-1:0] force_addr = '0;
    logic [PC_W-1:0] force_target = '0;
    bit              forced_done = 0;

    bit              drv_ack = 0;
    bit              drv_jmp = 0;
    bit              req_pre = 0;
    logic [PC_W-1:0] addr_pre = '0;
    logic [PC_W-1:0] jaddr_pre = '0;
    int              wait_left = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // stimulus and reference model: memory with random latency, jumps, ready, halt
    initial begin
        mem_ack = 1'b0; mem_rdata = '0; jmp_en = 1'b0; jmp_addr = '0;
        halt = 1'b0; instr_ready = 1'b0;
        exp_pc = '0; stale = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                exp_q.delete();
                exp_pc = '0; stale = 0;
                drv_ack = 0; drv_jmp = 0; wait_left = -1;
                mem_ack = 1'b0; jmp_en = 1'b0;
                continue;
            end

            // effect of the edge just taken
            if (drv_ack) begin
                if (!(drv_jmp || stale)) begin
                    exp_t e;
                    check("fetch_addr", 32'(addr_pre), 32'(exp_pc));
                    e.pc = exp_pc;
                    e.data = mem[exp_pc];
                    exp_q.push_back(e);
                    exp_pc = exp_pc + 1'b1;
                    check("fifo_bound", 32'(exp_q.size() <= DEPTH), 32'd1);
                end
                stale = 0;
            end
            if (drv_jmp) begin
                if (req_pre && !drv_ack) stale = 1;
                exp_q.delete();
                exp_pc = jaddr_pre;
            end

            // inputs for the next edge
            if (ready_mode == 2) instr_ready = 1'($urandom_range(1, 0));
            else instr_ready = (ready_mode == 1);
            if (halt_mode == 2) halt = ($urandom_range(99, 0) < 15);
            else halt = (halt_mode == 1);

            req_pre = mem_req;
            addr_pre = mem_addr;
            drv_ack = 0;
            if (!mem_req) begin
                wait_left = -1;
            end else begin
                if (wait_left < 0) wait_left = int'($urandom_range(max_wait, min_wait));
                if (wait_left == 0) begin
                    drv_ack = 1;
                    wait_left = -1;
                end else begin
                    wait_left--;
                end
            end
            mem_ack = drv_ack;
            mem_rdata = drv_ack ? mem[mem_addr] : 8'($urandom);

            drv_jmp = (jmp_pct > 0) && ($urandom_range(99, 0) < jmp_pct);
            jaddr_pre = PC_W'($urandom);
            if (force_mode == 1 && mem_req && mem_addr == force_addr && !drv_ack) begin
                drv_jmp = 1; jaddr_pre = force_target; force_mode = 0; forced_done = 1;
            end else if (force_mode == 2 && drv_ack && instr_valid && instr_ready) begin
                drv_jmp = 1; jaddr_pre = force_target; force_mode = 0; forced_done = 1;
            end
            jmp_en = drv_jmp;
            jmp_addr = jaddr_pre;
        end
    end

    // monitor: scores popped instructions and the request protocol
    bit              p_req = 0;
    bit              p_ack = 0;
    bit              p_halt = 0;
    logic [PC_W-1:0] p_addr = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_req = 0; p_ack = 0; p_halt = 0;
                continue;
            end
            check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
            if (p_req && !p_ack) begin
                check("req_held", 32'(mem_req), 32'd1);
                check("addr_stable", 32'(mem_addr), 32'(p_addr));
            end
            if (mem_req && (!p_req || p_ack)) check("new_req_under_halt", 32'(p_halt), 32'd0);
            if (instr_valid && instr_ready && !jmp_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: instr_pc %0h popped, required none", instr_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("instr_pc", 32'(instr_pc), 32'(e.pc));
                    check("instr", 32'(instr), 32'(e.data));
                end
            end
            p_req = mem_req; p_ack = mem_ack; p_addr = mem_addr; p_halt = halt;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr"}, 32'(instr), 32'd0);
        check({tag, "_instr_pc"}, 32'(instr_pc), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string name, input int limit);
        int n = 0;
        while (mem_req !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(mem_req), 32'd1);
    endtask

    task automatic wait_forced(input string name, input int limit);
        int n = 0;
        while (!forced_done && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(forced_done), 32'd1);
        forced_done = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);

        #2;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // FIFO fills with pc 0,1 then requests stop
        ready_mode = 0;
        repeat (10) @(negedge clk);
        check("full_no_req", 32'(mem_req), 32'd0);
        check("full_head_pc", 32'(instr_pc), 32'd0);

        // drain and stream with 1-cycle acks, long enough to wrap 31 -> 0
        ready_mode = 1;
        repeat (45) @(negedge clk);

        // 3-cycle wait states
        min_wait = 3; max_wait = 3;
        repeat (30) @(negedge clk);

        // jump to 5 while the read to 3 is pending
        do_reset();
        force_addr = 5'd3; force_target = 5'd5; force_mode = 1;
        wait_forced("jump_pending_fired", 200);
        repeat (20) @(negedge clk);

        // jump on the same edge as an ack and a pop
        min_wait = 0; max_wait = 0;
        repeat (5) @(negedge clk);
        force_target = 5'd20; force_mode = 2;
        wait_forced("jump_ack_pop_fired", 200);
        @(negedge clk);
        check("jump_ack_mem_addr", 32'(mem_addr), 32'd20);
        repeat (10) @(negedge clk);

        // random mix
        min_wait = 0; max_wait = 3; ready_mode = 2; halt_mode = 2; jmp_pct = 8;
        repeat (3000) @(negedge clk);

        // halt during a pending read: byte still delivered, no new request
        jmp_pct = 0; halt_mode = 0; ready_mode = 1; min_wait = 3; max_wait = 3;
        wait_req("halt_req_seen", 50);
        halt_mode = 1;
        repeat (12) @(negedge clk);
        check("halt_no_req", 32'(mem_req), 32'd0);
        check("halt_drained", 32'(instr_valid), 32'd0);

        // asynchronous reset in the middle of a read
        halt_mode = 0;
        wait_req("midread_req_seen", 50);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midread");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        min_wait = 0; max_wait = 1;
        repeat (30) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
